// File: rtl/position_alert_pkg.sv
// Shared types and constants for the riding-position alert block.
package position_alert_pkg;

  // Position codes as delivered by the upstream sampler; anything above SEAT is invalid
  typedef enum logic [2:0] {
    DROPS = 3'd0,
    HOODS = 3'd1,
    TOPS  = 3'd2,
    BAR   = 3'd3,
    SEAT  = 3'd4
  } pos_code_t;

  localparam int NUM_POS  = 5;
  localparam int MAX_CODE = 4;

  // Burst sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEEP = 2'd1,
    GAP  = 2'd2
  } state_t;

  // One-hot LED pattern for a position (bit 0 = drops, bit 4 = seat)
  function automatic logic [NUM_POS-1:0] pos_onehot(input pos_code_t c);
    logic [NUM_POS-1:0] oh;
    oh    = '0;
    oh[c] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: starts high on clear, toggles every TONE_HALF enabled
// cycles, and idles low whenever neither clear nor enable is asserted.
module tone_gen #(
  parameter int TONE_HALF = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tone
);

  localparam int CW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(TONE_HALF - 1);

  logic [CW-1:0] cnt;

  // Half-period counter and tone register; clear wins over enable so every beep starts high
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tone <= 1'b1;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        tone <= ~tone;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt  <= '0;
      tone <= 1'b0;
    end
  end

endmodule

// File: rtl/position_alert_tx.sv
// Turns an accepted position code into code+1 beeps on the buzzer while the
// matching position LED is lit; invalid codes only raise a one-cycle error pulse.
module position_alert_tx
  import position_alert_pkg::*;
#(
  parameter int TONE_HALF = 65536,
  parameter int BEEP_LEN  = 6000000,
  parameter int GAP_LEN   = 6000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pos_valid,
  input  logic [2:0]         pos_code,
  output logic               pos_ready,
  output logic               busy,
  output logic               err_invalid,
  output logic [NUM_POS-1:0] BOARD_LEDs,
  output logic               BUZZER
);

  localparam int BCW    = (BEEP_LEN > 1) ? $clog2(BEEP_LEN) : 1;
  localparam int GCW    = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam int LEFT_W = $clog2(NUM_POS + 1);

  localparam logic [BCW-1:0] BEEP_LAST = BCW'(BEEP_LEN - 1);
  localparam logic [GCW-1:0] GAP_LAST  = GCW'(GAP_LEN - 1);

  state_t            state, next_state;
  logic [BCW-1:0]    beep_cnt, next_beep_cnt;
  logic [GCW-1:0]    gap_cnt, next_gap_cnt;
  logic [LEFT_W-1:0] beeps_left, next_beeps_left;
  pos_code_t         code_q, next_code;
  logic              next_err;
  logic              tone_en, tone_clr;

  // Sequencer: accepts codes in IDLE, then alternates BEEP/GAP until all beeps are played
  always_comb begin
    next_state      = state;
    next_beep_cnt   = beep_cnt;
    next_gap_cnt    = gap_cnt;
    next_beeps_left = beeps_left;
    next_code       = code_q;
    next_err        = 1'b0;
    tone_en         = 1'b0;
    tone_clr        = 1'b0;
    case (state)
      IDLE: begin
        if (pos_valid && pos_ready) begin
          if (pos_code <= 3'(MAX_CODE)) begin
            next_state      = BEEP;
            next_code       = pos_code_t'(pos_code);
            next_beeps_left = LEFT_W'(pos_code) + LEFT_W'(1);
            next_beep_cnt   = '0;
            tone_clr        = 1'b1;
          end else begin
            next_err = 1'b1;
          end
        end
      end
      BEEP: begin
        if (beep_cnt == BEEP_LAST) begin
          next_state   = GAP;
          next_gap_cnt = '0;
        end else begin
          next_beep_cnt = beep_cnt + 1'b1;
          tone_en       = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (beeps_left == LEFT_W'(1)) begin
            next_state      = IDLE;
            next_beeps_left = '0;
          end else begin
            next_state      = BEEP;
            next_beeps_left = beeps_left - 1'b1;
            next_beep_cnt   = '0;
            tone_clr        = 1'b1;
          end
        end else begin
          next_gap_cnt = gap_cnt + 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs, all derived from the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      beep_cnt    <= '0;
      gap_cnt     <= '0;
      beeps_left  <= '0;
      code_q      <= DROPS;
      pos_ready   <= 1'b1;
      busy        <= 1'b0;
      err_invalid <= 1'b0;
      BOARD_LEDs  <= '0;
    end else begin
      state       <= next_state;
      beep_cnt    <= next_beep_cnt;
      gap_cnt     <= next_gap_cnt;
      beeps_left  <= next_beeps_left;
      code_q      <= next_code;
      pos_ready   <= (next_state == IDLE);
      busy        <= (next_state != IDLE);
      err_invalid <= next_err;
      BOARD_LEDs  <= (next_state == IDLE) ? '0 : pos_onehot(next_code);
    end
  end

  tone_gen #(
    .TONE_HALF(TONE_HALF)
  ) u_tone (
    .clk (clk),
    .rst (rst),
    .en  (tone_en),
    .clr (tone_clr),
    .tone(BUZZER)
  );

endmodule

// File: tb/tb_position_alert_tx.sv
// Bench for position_alert_tx: a timeline model of each burst checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_position_alert_tx;
  import position_alert_pkg::*;

  localparam int TH  = 2;
  localparam int BL  = 8;
  localparam int GL  = 4;
  localparam int PER = BL + GL;

  logic       clk = 1'b0;
  logic       rst;
  logic       pos_valid;
  logic [2:0] pos_code;
  logic       pos_ready;
  logic       busy;
  logic       err_invalid;
  logic [4:0] leds;
  logic       buzzer;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model state: whether a burst plays, which code, cycles elapsed since it started
  bit m_active  = 1'b0;
  int m_code    = 0;
  int m_elapsed = 0;
  bit m_err     = 1'b0;

  always #5 clk = ~clk;

  position_alert_tx #(
    .TONE_HALF(TH),
    .BEEP_LEN (BL),
    .GAP_LEN  (GL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pos_valid  (pos_valid),
    .pos_code   (pos_code),
    .pos_ready  (pos_ready),
    .busy       (busy),
    .err_invalid(err_invalid),
    .BOARD_LEDs (leds),
    .BUZZER     (buzzer)
  );

  // Advance the burst timeline on each edge, mirroring what the next cycle must show
  always @(posedge clk) begin
    if (rst) begin
      m_active  = 1'b0;
      m_err     = 1'b0;
      m_elapsed = 0;
    end else begin
      m_err = 1'b0;
      if (m_active) begin
        m_elapsed++;
        if (m_elapsed == (m_code + 1) * PER) m_active = 1'b0;
      end else if (pos_valid) begin
        if (int'(pos_code) <= MAX_CODE) begin
          m_active  = 1'b1;
          m_code    = int'(pos_code);
          m_elapsed = 0;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  function automatic logic exp_buzzer();
    int p;
    p = m_elapsed % PER;
    return m_active && (p < BL) && (((p / TH) % 2) == 0);
  endfunction

  task automatic expectLit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  task automatic checkOutput();
    expectLit("model pos_ready", 32'(pos_ready), 32'(!m_active));
    expectLit("model busy", 32'(busy), 32'(m_active));
    expectLit("model err_invalid", 32'(err_invalid), 32'(m_err));
    expectLit("model BOARD_LEDs", 32'(leds), m_active ? (32'd1 << m_code) : 32'd0);
    expectLit("model BUZZER", 32'(buzzer), 32'(exp_buzzer()));
  endtask

  always @(negedge clk) begin
    if (chk_en) checkOutput();
  end

  task automatic applyStimulus(input logic v, input logic [2:0] c);
    @(negedge clk);
    pos_valid = v;
    pos_code  = c;
  endtask

  // Directed scenarios with hand-computed expectations
  initial begin
    logic [11:0] pat;
    int n;
    int ons;
    int errs_seen;
    pat = 12'b0000_0011_0011;

    rst       = 1'b1;
    pos_valid = 1'b1;
    pos_code  = 3'd0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    expectLit("reset pos_ready", 32'(pos_ready), 32'd1);
    expectLit("reset busy", 32'(busy), 32'd0);
    expectLit("reset BOARD_LEDs", 32'(leds), 32'd0);
    expectLit("reset BUZZER", 32'(buzzer), 32'd0);
    expectLit("reset err_invalid", 32'(err_invalid), 32'd0);
    @(negedge clk);
    expectLit("reset held no transfer", 32'(busy), 32'd0);
    rst       = 1'b0;
    pos_valid = 1'b0;

    // Code 0: one beep, buzzer 1,1,0,0,1,1,0,0 then four silent cycles
    applyStimulus(1'b1, 3'd0);
    @(negedge clk);
    pos_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      expectLit("code0 BUZZER", 32'(buzzer), 32'(pat[i]));
      expectLit("code0 BOARD_LEDs", 32'(leds), 32'b00001);
      expectLit("code0 busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    expectLit("code0 done busy", 32'(busy), 32'd0);
    expectLit("code0 done ready", 32'(pos_ready), 32'd1);

    // Code 4: five beeps, 60 busy cycles
    applyStimulus(1'b1, 3'd4);
    @(negedge clk);
    pos_valid = 1'b0;
    n = 0;
    ons = 0;
    while (busy && n < 200) begin
      expectLit("code4 BOARD_LEDs", 32'(leds), 32'b10000);
      if (buzzer) ons++;
      n++;
      @(negedge clk);
    end
    expectLit("code4 busy cycles", 32'(n), 32'd60);
    expectLit("code4 tone-on cycles", 32'(ons), 32'd20);
    expectLit("code4 LEDs after", 32'(leds), 32'd0);

    // Code 6: invalid, single error pulse
    applyStimulus(1'b1, 3'd6);
    @(negedge clk);
    pos_valid = 1'b0;
    expectLit("code6 err pulse", 32'(err_invalid), 32'd1);
    expectLit("code6 ready", 32'(pos_ready), 32'd1);
    expectLit("code6 LEDs", 32'(leds), 32'd0);
    expectLit("code6 BUZZER", 32'(buzzer), 32'd0);
    errs_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (err_invalid) errs_seen++;
    end
    expectLit("code6 err width", 32'(errs_seen), 32'd0);

    // Back-to-back: code 1 then code 3 held valid
    applyStimulus(1'b1, 3'd1);
    @(negedge clk);
    pos_code = 3'd3;
    n = 1;
    while (!pos_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    expectLit("b2b ready cycle", 32'(n), 32'd25);
    @(negedge clk);
    expectLit("b2b LEDs", 32'(leds), 32'b01000);
    expectLit("b2b ready low", 32'(pos_ready), 32'd0);
    pos_valid = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    expectLit("b2b code3 busy cycles", 32'(n), 32'd48);

    // Reset during the third beep of code 2, then a fresh code 0
    applyStimulus(1'b1, 3'd2);
    @(negedge clk);
    pos_valid = 1'b0;
    for (int i = 0; i < 26; i++) @(negedge clk);
    expectLit("rst mid beep busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    expectLit("rst mid BUZZER", 32'(buzzer), 32'd0);
    expectLit("rst mid LEDs", 32'(leds), 32'd0);
    expectLit("rst mid busy", 32'(busy), 32'd0);
    expectLit("rst mid ready", 32'(pos_ready), 32'd1);
    rst = 1'b0;
    applyStimulus(1'b1, 3'd0);
    @(negedge clk);
    pos_valid = 1'b0;
    n = 0;
    ons = 0;
    while (busy && n < 200) begin
      if (buzzer) ons++;
      n++;
      @(negedge clk);
    end
    expectLit("post-rst busy cycles", 32'(n), 32'd12);
    expectLit("post-rst tone-on cycles", 32'(ons), 32'd4);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Time limit so a stuck design cannot hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
